// File: rtl/test_monitor_pkg.sv
// Shared types for the test result monitor.
//   verdict_t    : 2-bit per-channel verdict as seen on chan_verdict
//   chan_state_t : per-channel FSM state
//   state_verdict / state_terminal : map an FSM state to its output view
package test_monitor_pkg;

  typedef enum logic [1:0] {
    NONE    = 2'd0,
    PASS    = 2'd1,
    FAIL    = 2'd2,
    TIMEOUT = 2'd3
  } verdict_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARM,
    ST_RUN,
    ST_PASS,
    ST_FAIL,
    ST_TIMEOUT
  } chan_state_t;

  localparam int unsigned ELAPSED_W = 32;

  function automatic verdict_t state_verdict(input chan_state_t s);
    case (s)
      ST_PASS:    return PASS;
      ST_FAIL:    return FAIL;
      ST_TIMEOUT: return TIMEOUT;
      default:    return NONE;
    endcase
  endfunction

  function automatic logic state_terminal(input chan_state_t s);
    return (s == ST_PASS) || (s == ST_FAIL) || (s == ST_TIMEOUT);
  endfunction

endpackage

// File: rtl/test_result_monitor_if.sv
// Bundle of the monitor's control/status signals.
//   master : test controller side (drives start and the GPIO inputs)
//   slave  : monitor side (drives verdicts, aggregates and elapsed)
interface test_result_monitor_if #(
  parameter int unsigned NUM_CHANNELS = 2
);

  logic                             start;
  logic [NUM_CHANNELS-1:0]          success_in;
  logic [NUM_CHANNELS-1:0]          fail_in;
  logic [NUM_CHANNELS-1:0][1:0]     chan_verdict;
  logic [NUM_CHANNELS-1:0]          chan_done;
  logic                             all_done;
  logic                             all_pass;
  logic                             any_fail;
  logic [31:0]                      elapsed;

  modport master (
    output start, success_in, fail_in,
    input  chan_verdict, chan_done, all_done, all_pass, any_fail, elapsed
  );

  modport slave (
    input  start, success_in, fail_in,
    output chan_verdict, chan_done, all_done, all_pass, any_fail, elapsed
  );

endinterface

// File: rtl/test_monitor_channel.sv
// One monitored channel: IDLE -> ARM -> RUN -> {PASS, FAIL, TIMEOUT}.
// Ports:
//   clk, rst    : clock, synchronous active-high reset
//   start_i     : restart pulse, moves to ARM (or RUN when ARM_DELAY=0)
//   success_i   : success GPIO, glitch-filtered in RUN
//   fail_i      : fail GPIO, glitch-filtered in RUN, wins over success
//   verdict_o   : registered verdict
//   done_o      : registered, channel is in a terminal state
//   running_o   : channel is currently in RUN
module test_monitor_channel
  import test_monitor_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned FILTER_CYCLES  = 1,
  parameter int unsigned ARM_DELAY      = 2
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     start_i,
  input  logic     success_i,
  input  logic     fail_i,
  output verdict_t verdict_o,
  output logic     done_o,
  output logic     running_o
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned FW = $clog2(FILTER_CYCLES + 1);
  localparam int unsigned AW = (ARM_DELAY > 1) ? $clog2(ARM_DELAY) : 1;

  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_CYCLES - 1);
  localparam logic [AW-1:0] ARM_LAST  = AW'((ARM_DELAY > 0) ? ARM_DELAY - 1 : 0);

  chan_state_t   state_q, state_d;
  logic [AW-1:0] arm_q, arm_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [FW-1:0] sfilt_q, sfilt_d;
  logic [FW-1:0] ffilt_q, ffilt_d;
  verdict_t      verdict_q;
  logic          done_q;

  logic s_qual;
  logic f_qual;

  // An input qualifies on its FILTER_CYCLES-th consecutive high RUN cycle.
  always_comb begin
    s_qual = (state_q == ST_RUN) && success_i && (sfilt_q == FILT_LAST);
    f_qual = (state_q == ST_RUN) && fail_i    && (ffilt_q == FILT_LAST);
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    tmo_d   = tmo_q;
    sfilt_d = '0;
    ffilt_d = '0;
    if (start_i) begin
      arm_d   = '0;
      tmo_d   = '0;
      state_d = (ARM_DELAY == 0) ? ST_RUN : ST_ARM;
    end else begin
      case (state_q)
        ST_ARM: begin
          if (arm_q == ARM_LAST) begin
            state_d = ST_RUN;
            tmo_d   = '0;
          end else begin
            arm_d = arm_q + AW'(1);
          end
        end
        ST_RUN: begin
          sfilt_d = success_i ? sfilt_q + FW'(1) : '0;
          ffilt_d = fail_i    ? ffilt_q + FW'(1) : '0;
          tmo_d   = tmo_q + TW'(1);
          // Qualified inputs outrank the timeout on the same cycle.
          if (f_qual) begin
            state_d = ST_FAIL;
          end else if (s_qual) begin
            state_d = ST_PASS;
          end else if (tmo_q == TMO_LAST) begin
            state_d = ST_TIMEOUT;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      arm_q     <= '0;
      tmo_q     <= '0;
      sfilt_q   <= '0;
      ffilt_q   <= '0;
      verdict_q <= NONE;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      arm_q     <= arm_d;
      tmo_q     <= tmo_d;
      sfilt_q   <= sfilt_d;
      ffilt_q   <= ffilt_d;
      verdict_q <= state_verdict(state_d);
      done_q    <= state_terminal(state_d);
    end
  end

  assign verdict_o = verdict_q;
  assign done_o    = done_q;
  assign running_o = (state_q == ST_RUN);

endmodule

// File: rtl/test_result_monitor.sv
// Monitors NUM_CHANNELS success/fail GPIO pairs after a start pulse and
// reports per-channel and aggregate verdicts plus the RUN cycle count.
// Ports:
//   clk, rst      : clock, synchronous active-high reset (beats start)
//   start         : single-cycle (re)start of all channels
//   success_in    : per-channel success GPIO
//   fail_in       : per-channel fail GPIO
//   chan_verdict  : per-channel verdict_t (NONE/PASS/FAIL/TIMEOUT)
//   chan_done     : per-channel terminal flag
//   all_done      : every channel terminal
//   all_pass      : every channel PASS
//   any_fail      : some channel FAIL or TIMEOUT
//   elapsed       : cycles with any channel in RUN, saturating
module test_result_monitor
  import test_monitor_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS   = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned FILTER_CYCLES  = 1,
  parameter int unsigned ARM_DELAY      = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [NUM_CHANNELS-1:0]      success_in,
  input  logic [NUM_CHANNELS-1:0]      fail_in,
  output logic [NUM_CHANNELS-1:0][1:0] chan_verdict,
  output logic [NUM_CHANNELS-1:0]      chan_done,
  output logic                         all_done,
  output logic                         all_pass,
  output logic                         any_fail,
  output logic [ELAPSED_W-1:0]         elapsed
);

  verdict_t                verdict_w [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0] running_w;

  for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_chan
    test_monitor_channel #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .FILTER_CYCLES  (FILTER_CYCLES),
      .ARM_DELAY      (ARM_DELAY)
    ) u_chan (
      .clk       (clk),
      .rst       (rst),
      .start_i   (start),
      .success_i (success_in[g]),
      .fail_i    (fail_in[g]),
      .verdict_o (verdict_w[g]),
      .done_o    (chan_done[g]),
      .running_o (running_w[g])
    );
    assign chan_verdict[g] = verdict_w[g];
  end

  // Aggregates are decoded from the registered verdicts so they change on
  // the same cycle as chan_verdict.
  always_comb begin
    all_pass = 1'b1;
    any_fail = 1'b0;
    for (int unsigned i = 0; i < NUM_CHANNELS; i++) begin
      if (verdict_w[i] != PASS) all_pass = 1'b0;
      if (verdict_w[i] == FAIL || verdict_w[i] == TIMEOUT) any_fail = 1'b1;
    end
    all_done = &chan_done;
  end

  logic [ELAPSED_W-1:0] elapsed_q, elapsed_d;

  always_comb begin
    elapsed_d = elapsed_q;
    if (start) begin
      elapsed_d = '0;
    end else if ((|running_w) && (elapsed_q != '1)) begin
      elapsed_d = elapsed_q + ELAPSED_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      elapsed_q <= '0;
    end else begin
      elapsed_q <= elapsed_d;
    end
  end

  assign elapsed = elapsed_q;

endmodule

// File: tb/tb_test_result_monitor.sv
module tb_test_result_monitor;

  localparam int ND = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  test_result_monitor_if #(.NUM_CHANNELS(2)) ifa ();
  test_result_monitor_if #(.NUM_CHANNELS(2)) ifb ();
  test_result_monitor_if #(.NUM_CHANNELS(2)) ifc ();

  // dut_a: defaults, dut_b: FILTER_CYCLES=3, dut_c: TIMEOUT_CYCLES=16
  test_result_monitor #(.NUM_CHANNELS(2)) dut_a (
    .clk(clk), .rst(rst), .start(ifa.start), .success_in(ifa.success_in),
    .fail_in(ifa.fail_in), .chan_verdict(ifa.chan_verdict), .chan_done(ifa.chan_done),
    .all_done(ifa.all_done), .all_pass(ifa.all_pass), .any_fail(ifa.any_fail),
    .elapsed(ifa.elapsed)
  );
  test_result_monitor #(.NUM_CHANNELS(2), .FILTER_CYCLES(3)) dut_b (
    .clk(clk), .rst(rst), .start(ifb.start), .success_in(ifb.success_in),
    .fail_in(ifb.fail_in), .chan_verdict(ifb.chan_verdict), .chan_done(ifb.chan_done),
    .all_done(ifb.all_done), .all_pass(ifb.all_pass), .any_fail(ifb.any_fail),
    .elapsed(ifb.elapsed)
  );
  test_result_monitor #(.NUM_CHANNELS(2), .TIMEOUT_CYCLES(16)) dut_c (
    .clk(clk), .rst(rst), .start(ifc.start), .success_in(ifc.success_in),
    .fail_in(ifc.fail_in), .chan_verdict(ifc.chan_verdict), .chan_done(ifc.chan_done),
    .all_done(ifc.all_done), .all_pass(ifc.all_pass), .any_fail(ifc.any_fail),
    .elapsed(ifc.elapsed)
  );

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic start_pulse(input int d);
    case (d)
      0: ifa.start = 1'b1;
      1: ifb.start = 1'b1;
      default: ifc.start = 1'b1;
    endcase
    tick(1);
    ifa.start = 1'b0;
    ifb.start = 1'b0;
    ifc.start = 1'b0;
  endtask

  // Packed view: {verdict[1], verdict[0], done[1:0], all_done, all_pass, any_fail, elapsed}
  function automatic logic [40:0] vec_a();
    return {ifa.chan_verdict, ifa.chan_done, ifa.all_done, ifa.all_pass, ifa.any_fail, ifa.elapsed};
  endfunction
  function automatic logic [40:0] vec_b();
    return {ifb.chan_verdict, ifb.chan_done, ifb.all_done, ifb.all_pass, ifb.any_fail, ifb.elapsed};
  endfunction
  function automatic logic [40:0] vec_c();
    return {ifc.chan_verdict, ifc.chan_done, ifc.all_done, ifc.all_pass, ifc.any_fail, ifc.elapsed};
  endfunction

  // ---------------- behavioural model ----------------
  // Each channel is described by the number of cycles since its start (k):
  // the first p_arm cycles are arming, afterwards cycle k-p_arm is RUN index.
  function automatic int p_arm(input int d);
    return 2;
  endfunction
  function automatic int p_filter(input int d);
    return (d == 1) ? 3 : 1;
  endfunction
  function automatic int p_timeout(input int d);
    return (d == 2) ? 16 : 1000000;
  endfunction

  bit     m_started [ND][2];
  int     m_k       [ND][2];
  int     m_ss      [ND][2];
  int     m_fs      [ND][2];
  int     m_v       [ND][2];
  longint m_el      [ND];
  bit     model_ok = 1'b0;

  function automatic logic [40:0] model_vec(input int d);
    logic [3:0] v;
    logic [1:0] dn;
    logic       ad, ap, af;
    v  = {2'(m_v[d][1]), 2'(m_v[d][0])};
    dn = {m_v[d][1] != 0, m_v[d][0] != 0};
    ad = &dn;
    ap = (m_v[d][0] == 1) && (m_v[d][1] == 1);
    af = (m_v[d][0] >= 2) || (m_v[d][1] >= 2);
    return {v, dn, ad, ap, af, 32'(m_el[d])};
  endfunction

  initial begin
    logic       r;
    logic       st [ND];
    logic [1:0] sc [ND];
    logic [1:0] fl [ND];
    bit         anyrun;
    forever begin
      @(posedge clk);
      r = rst;
      st[0] = ifa.start; sc[0] = ifa.success_in; fl[0] = ifa.fail_in;
      st[1] = ifb.start; sc[1] = ifb.success_in; fl[1] = ifb.fail_in;
      st[2] = ifc.start; sc[2] = ifc.success_in; fl[2] = ifc.fail_in;
      for (int d = 0; d < ND; d++) begin
        if (r) begin
          model_ok = 1'b1;
          m_el[d] = 0;
          for (int c = 0; c < 2; c++) begin
            m_started[d][c] = 1'b0;
            m_v[d][c] = 0;
          end
        end else if (st[d]) begin
          m_el[d] = 0;
          for (int c = 0; c < 2; c++) begin
            m_started[d][c] = 1'b1;
            m_k[d][c] = 0; m_ss[d][c] = 0; m_fs[d][c] = 0; m_v[d][c] = 0;
          end
        end else begin
          anyrun = 1'b0;
          for (int c = 0; c < 2; c++)
            if (m_started[d][c] && m_v[d][c] == 0 && m_k[d][c] >= p_arm(d)) anyrun = 1'b1;
          if (anyrun && m_el[d] < 64'hFFFF_FFFF) m_el[d]++;
          for (int c = 0; c < 2; c++) begin
            if (m_started[d][c] && m_v[d][c] == 0) begin
              if (m_k[d][c] >= p_arm(d)) begin
                m_ss[d][c] = sc[d][c] ? m_ss[d][c] + 1 : 0;
                m_fs[d][c] = fl[d][c] ? m_fs[d][c] + 1 : 0;
                if (m_fs[d][c] >= p_filter(d)) m_v[d][c] = 2;
                else if (m_ss[d][c] >= p_filter(d)) m_v[d][c] = 1;
                else if (m_k[d][c] - p_arm(d) == p_timeout(d) - 1) m_v[d][c] = 3;
              end
              m_k[d][c]++;
            end
          end
        end
      end
      @(negedge clk);
      if (model_ok) begin
        check("dut_a_vs_model", vec_a(), model_vec(0));
        check("dut_b_vs_model", vec_b(), model_vec(1));
        check("dut_c_vs_model", vec_c(), model_vec(2));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1;
    ifa.start = 1'b0; ifa.success_in = '0; ifa.fail_in = '0;
    ifb.start = 1'b0; ifb.success_in = '0; ifb.fail_in = '0;
    ifc.start = 1'b0; ifc.success_in = '0; ifc.fail_in = '0;
    tick(3);
    check("a_reset_outputs", vec_a(), 64'd0);
    check("b_reset_outputs", vec_b(), 64'd0);
    check("c_reset_outputs", vec_c(), 64'd0);
    rst = 1'b0;
    tick(1);

    // Both channels pass: ch0 at RUN cycle 5, ch1 at RUN cycle 9.
    start_pulse(0);
    tick(2);
    tick(5); ifa.success_in = 2'b01;
    tick(4); ifa.success_in = 2'b11;
    tick(1);
    check("a_both_pass_verdict", ifa.chan_verdict, 4'b0101);
    check("a_both_pass_all_pass", ifa.all_pass, 1'b1);
    check("a_both_pass_all_done", ifa.all_done, 1'b1);
    check("a_both_pass_elapsed", ifa.elapsed, 32'd10);
    ifa.success_in = '0;
    tick(3);
    check("a_sticky_pass", vec_a(), {4'b0101, 2'b11, 3'b110, 32'd10});

    // Simultaneous fail and success on ch0: fail wins.
    start_pulse(0);
    tick(2);
    check("a_restart_clears", vec_a(), 64'd0);
    tick(3); ifa.success_in = 2'b01; ifa.fail_in = 2'b01;
    tick(1);
    check("a_fail_wins_verdict", ifa.chan_verdict, 4'b0010);
    check("a_fail_wins_any_fail", ifa.any_fail, 1'b1);
    check("a_fail_wins_all_done", ifa.all_done, 1'b0);
    ifa.success_in = '0; ifa.fail_in = '0;

    // Inputs high only while arming give no verdict.
    start_pulse(0);
    ifa.success_in = 2'b11;
    tick(1);
    ifa.success_in = '0;
    tick(1);
    check("a_arm_ignored", ifa.chan_verdict, 4'b0000);
    tick(4);
    check("a_run_elapsed", ifa.elapsed, 32'd4);
    // Restart mid-RUN.
    start_pulse(0);
    check("a_midrun_restart", vec_a(), 64'd0);
    tick(5);

    // Reset together with start while running.
    rst = 1'b1; ifa.start = 1'b1;
    tick(1);
    check("a_rst_beats_start", vec_a(), 64'd0);
    rst = 1'b0; ifa.start = 1'b0;
    tick(3);
    check("a_idle_after_rst", vec_a(), 64'd0);
    start_pulse(0);
    tick(4); ifa.fail_in = 2'b10;
    tick(1);
    check("a_arm_after_rst", ifa.chan_verdict, 4'b1000);
    ifa.fail_in = '0;

    // Filter of 3 on dut_b: 2 high, 1 low, then 3 high.
    start_pulse(1);
    tick(2);
    ifb.fail_in = 2'b10; tick(2);
    ifb.fail_in = 2'b00; tick(1);
    ifb.fail_in = 2'b10; tick(2);
    check("b_filter_not_yet", ifb.chan_verdict, 4'b0000);
    tick(1);
    check("b_filter_fail", ifb.chan_verdict, 4'b1000);
    check("b_filter_any_fail", ifb.any_fail, 1'b1);
    ifb.fail_in = '0;

    // Timeout of 16 on dut_c.
    start_pulse(2);
    tick(2);
    tick(15);
    check("c_before_timeout", ifc.chan_verdict, 4'b0000);
    tick(1);
    check("c_timeout", vec_c(), {4'b1111, 2'b11, 3'b101, 32'd16});
    start_pulse(2);
    tick(2);
    tick(15); ifc.success_in = 2'b11;
    tick(1);
    check("c_pass_on_last_cycle", vec_c(), {4'b0101, 2'b11, 3'b110, 32'd16});
    ifc.success_in = '0;
    start_pulse(2);
    tick(2);
    tick(15); ifc.success_in = 2'b01;
    tick(1);
    check("c_mixed_pass_timeout", vec_c(), {4'b1101, 2'b11, 3'b101, 32'd16});
    ifc.success_in = '0;

    tick(2);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/test_result_monitor.md
TEST_RESULT_MONITOR -- requirements
Module: test_result_monitor

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 2: number of independent success/fail GPIO pairs monitored.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1_000_000: RUN cycles allowed per channel before a TIMEOUT verdict.
REQ-003 SHALL have parameter FILTER_CYCLES, default 1: consecutive high cycles an input needs to qualify; legal values are ≥1.
REQ-004 SHALL have parameter ARM_DELAY, default 2: cycles after start during which inputs are ignored; legal values are ≥0.
REQ-005 SHALL have port clk, input, 1 bit: the single clock.
REQ-006 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port start, input, 1 bit: single-cycle pulse that (re)starts all channels.
REQ-008 SHALL have port success_in, input, NUM_CHANNELS bits: per-channel success GPIO.
REQ-009 SHALL have port fail_in, input, NUM_CHANNELS bits: per-channel fail GPIO.
REQ-010 SHALL have port chan_verdict, output, NUM_CHANNELS x 2 bits: per-channel verdict_t.
REQ-011 SHALL have port chan_done, output, NUM_CHANNELS bits: channel is in a terminal state.
REQ-012 SHALL have ports all_done, all_pass and any_fail, outputs, 1 bit each: aggregate status.
REQ-013 SHALL have port elapsed, output, 32 bits: RUN cycle count, saturating at 32'hFFFF_FFFF.

Function
REQ-014 Per-channel FSM SHALL have states IDLE, ARM, RUN, PASS, FAIL and TIMEOUT.
REQ-015 start SHALL move every channel to ARM on the next cycle, from any state; this covers a restart mid-RUN.
REQ-016 ARM SHALL last exactly ARM_DELAY cycles, then go to RUN; with ARM_DELAY=0, start SHALL go directly to RUN.
REQ-017 In ARM, filter counters SHALL be held at 0 and inputs ignored.
REQ-018 In RUN, an input SHALL qualify once it is high for FILTER_CYCLES consecutive cycles; any low cycle SHALL clear that input's filter counter.
REQ-019 A qualified fail SHALL move the channel to FAIL on the next cycle; a qualified success SHALL move it to PASS.
REQ-020 If fail and success qualify in the same cycle, fail SHALL win and the channel SHALL go to FAIL.
REQ-021 The timeout counter SHALL be cleared on RUN entry and increment each RUN cycle; at count TIMEOUT_CYCLES-1 with no qualified input, the channel SHALL go to TIMEOUT next cycle.
REQ-022 A qualified input on the timeout cycle SHALL take priority over TIMEOUT.
REQ-023 PASS, FAIL and TIMEOUT SHALL be sticky until start or rst; input changes SHALL be ignored while terminal.
REQ-024 chan_verdict SHALL encode NONE=0 in IDLE, ARM and RUN, PASS=1, FAIL=2, TIMEOUT=3; outputs SHALL be registered and reflect the state the cycle after the transition decision.
REQ-025 chan_done[i] SHALL be 1 iff channel i is in PASS, FAIL or TIMEOUT.
REQ-026 all_done SHALL be the AND of chan_done.
REQ-027 all_pass SHALL be 1 iff every verdict is PASS.
REQ-028 any_fail SHALL be 1 iff any verdict is FAIL or TIMEOUT.
REQ-029 elapsed SHALL be cleared by start and SHALL increment while any channel is in RUN.

Reset
REQ-030 rst SHALL force all channels to IDLE, clear all counters, set chan_verdict=0, chan_done=0, all_done=0, all_pass=0, any_fail=0 and elapsed=0.
REQ-031 rst SHALL take priority over start asserted in the same cycle; a start while IDLE after reset SHALL arm normally.

Structure
REQ-032 Package test_monitor_pkg SHALL hold the verdict_t enum (2-bit) and the channel state enum.
REQ-033 Per-channel FSM, filter and timeout counter SHALL live in sub-module test_monitor_channel, instantiated NUM_CHANNELS times.
REQ-034 Timeout counter width SHALL be $clog2(TIMEOUT_CYCLES+1); filter counter width SHALL be $clog2(FILTER_CYCLES+1).

Verification
REQ-035 Defaults; start; success_in[0]=1 at RUN cycle 5, success_in[1]=1 at RUN cycle 9 -> both verdicts PASS; all_pass=1; all_done=1; elapsed=10.
REQ-036 FILTER_CYCLES=3; fail_in[1] high 2 cycles, low 1, high 3 -> FAIL only after the third cycle of the second burst; any_fail=1.
REQ-037 fail_in[0] and success_in[0] rise in the same RUN cycle -> chan_verdict[0]=FAIL.
REQ-038 TIMEOUT_CYCLES=16, no inputs -> both channels TIMEOUT exactly 16 RUN cycles after entry; success_in asserted on cycle 16 instead -> PASS.
REQ-039 Inputs high during ARM (ARM_DELAY=2) -> no verdict from ARM alone; a restart mid-RUN clears elapsed and verdicts.
REQ-040 rst asserted with start in the same cycle while RUN -> all outputs 0 and channels IDLE next cycle.
